// File: rtl/psram_responder_if.sv
// Serial PSRAM pin bundle between a controller (master) and the responder model (slave).
interface psram_responder_if;
  logic       i_psram_sclk;
  logic       i_psram_cs;
  logic [3:0] i_psram_sio;
  logic [3:0] o_psram_sio;
  logic       o_psram_oe;
  logic       o_qpi;
  logic       o_busy;

  modport master (
    output i_psram_sclk, i_psram_cs, i_psram_sio,
    input  o_psram_sio, o_psram_oe, o_qpi, o_busy
  );

  modport slave (
    input  i_psram_sclk, i_psram_cs, i_psram_sio,
    output o_psram_sio, o_psram_oe, o_qpi, o_busy
  );
endinterface

// File: rtl/psram_responder.sv
// PSRAM responder: oversamples sclk/cs in clkRAM and serves 0x35/0x38/0xEB from an internal byte array.
// Define PSRAM_RESP_BURST_EN to continue bursts at addr+1 while cs stays low.
module psram_responder #(
  parameter int MEM_ADDR_BITS = 10,
  parameter int WAIT_CYCLES   = 7
) (
  input logic               clkRAM,
  input logic               reset,
  psram_responder_if.slave  bus
);
  localparam int WW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [WW-1:0] WAIT_LAST = (WAIT_CYCLES < 1) ? '0 : WW'(WAIT_CYCLES - 1);
`ifdef PSRAM_RESP_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_WDATA, ST_WAIT, ST_RDATA, ST_IGNORE
  } state_t;

  logic [1:0] sclk_sync_reg, cs_sync_reg;
  logic       sclk_prev_reg, cs_prev_reg;
  logic [3:0] sio_s1_reg, sio_s2_reg;
  logic       sclk_rise, sclk_fall, cs_rise, cs_fall;

  // sio rides the same two-flop delay as sclk so data lines up with the detected edge
  always_ff @(posedge clkRAM) begin
    if (reset) begin
      sclk_sync_reg <= 2'b00;
      cs_sync_reg   <= 2'b11;
      sclk_prev_reg <= 1'b0;
      cs_prev_reg   <= 1'b1;
      sio_s1_reg    <= 4'h0;
      sio_s2_reg    <= 4'h0;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[0], bus.i_psram_sclk};
      cs_sync_reg   <= {cs_sync_reg[0], bus.i_psram_cs};
      sclk_prev_reg <= sclk_sync_reg[1];
      cs_prev_reg   <= cs_sync_reg[1];
      sio_s1_reg    <= bus.i_psram_sio;
      sio_s2_reg    <= sio_s1_reg;
    end
  end

  assign sclk_rise = sclk_sync_reg[1] & ~sclk_prev_reg;
  assign sclk_fall = ~sclk_sync_reg[1] & sclk_prev_reg;
  assign cs_rise   = cs_sync_reg[1] & ~cs_prev_reg;
  assign cs_fall   = ~cs_sync_reg[1] & cs_prev_reg;

  state_t                   state_reg;
  logic [6:0]               cmd_reg;
  logic [2:0]               bit_cnt_reg, nib_cnt_reg;
  logic [WW-1:0]            wait_cnt_reg;
  logic [MEM_ADDR_BITS-1:0] addr_reg;
  logic                     wr_flag_reg, rd_phase_reg;
  logic [3:0]               wdata_hi_reg, sio_out_reg;
  logic                     oe_reg, qpi_reg, busy_reg;
  logic [7:0]               cmd_full;

  logic [7:0] mem [0:(2**MEM_ADDR_BITS)-1];
  logic [7:0] mem_q;
  logic       mem_we;

  assign cmd_full = {cmd_reg, sio_s2_reg[0]};
  assign mem_we   = !reset && !cs_rise && sclk_rise && (state_reg == ST_WDATA) && (nib_cnt_reg == 3'd1);

  always_ff @(posedge clkRAM) begin
    if (mem_we) mem[addr_reg] <= {wdata_hi_reg, sio_s2_reg};
    mem_q <= mem[addr_reg];
  end

  always_ff @(posedge clkRAM) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      cmd_reg      <= '0;
      bit_cnt_reg  <= '0;
      nib_cnt_reg  <= '0;
      wait_cnt_reg <= '0;
      addr_reg     <= '0;
      wr_flag_reg  <= 1'b0;
      rd_phase_reg <= 1'b0;
      wdata_hi_reg <= '0;
      sio_out_reg  <= '0;
      oe_reg       <= 1'b0;
      qpi_reg      <= 1'b0;
      busy_reg     <= 1'b0;
    end else if (cs_rise) begin
      state_reg    <= ST_IDLE;
      oe_reg       <= 1'b0;
      busy_reg     <= 1'b0;
      bit_cnt_reg  <= '0;
      nib_cnt_reg  <= '0;
      wait_cnt_reg <= '0;
      rd_phase_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: if (cs_fall) begin
          state_reg   <= ST_CMD;
          bit_cnt_reg <= '0;
          cmd_reg     <= '0;
          busy_reg    <= 1'b1;
        end
        ST_CMD: if (sclk_rise) begin
          cmd_reg <= cmd_full[6:0];
          if (bit_cnt_reg == 3'd7) begin
            bit_cnt_reg <= '0;
            nib_cnt_reg <= '0;
            case (cmd_full)
              8'h35: begin qpi_reg <= 1'b1; state_reg <= ST_IGNORE; end
              8'h38: begin wr_flag_reg <= 1'b1; state_reg <= ST_ADDR; end
              8'hEB: begin wr_flag_reg <= 1'b0; state_reg <= ST_ADDR; end
              default: state_reg <= ST_IGNORE;
            endcase
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
          end
        end
        // Address bits above the array width simply shift out, giving the aliasing
        ST_ADDR: if (sclk_rise) begin
          addr_reg <= MEM_ADDR_BITS'({addr_reg, sio_s2_reg});
          if (nib_cnt_reg == 3'd4) begin
            nib_cnt_reg  <= '0;
            wait_cnt_reg <= '0;
            rd_phase_reg <= 1'b0;
            if (wr_flag_reg)           state_reg <= ST_WDATA;
            else if (WAIT_CYCLES == 0) state_reg <= ST_RDATA;
            else                       state_reg <= ST_WAIT;
          end else begin
            nib_cnt_reg <= nib_cnt_reg + 3'd1;
          end
        end
        ST_WDATA: if (sclk_rise) begin
          if (nib_cnt_reg == 3'd0) begin
            wdata_hi_reg <= sio_s2_reg;
            nib_cnt_reg  <= 3'd1;
          end else begin
            nib_cnt_reg <= '0;
            if (BURST) addr_reg  <= addr_reg + 1'b1;
            else       state_reg <= ST_IGNORE;
          end
        end
        ST_WAIT: if (sclk_rise) begin
          if (wait_cnt_reg == WAIT_LAST) begin
            wait_cnt_reg <= '0;
            rd_phase_reg <= 1'b0;
            state_reg    <= ST_RDATA;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + WW'(1);
          end
        end
        // Advancing addr on the low nibble lets mem_q prefetch the next burst byte
        ST_RDATA: if (sclk_fall) begin
          oe_reg <= 1'b1;
          if (!rd_phase_reg) begin
            sio_out_reg  <= mem_q[7:4];
            rd_phase_reg <= 1'b1;
          end else begin
            sio_out_reg  <= mem_q[3:0];
            rd_phase_reg <= 1'b0;
            if (BURST) addr_reg  <= addr_reg + 1'b1;
            else       state_reg <= ST_IGNORE;
          end
        end
        // The low nibble of a single read stays driven until the next falling edge
        ST_IGNORE: if (sclk_fall) oe_reg <= 1'b0;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_psram_sio = sio_out_reg;
  assign bus.o_psram_oe  = oe_reg;
  assign bus.o_qpi       = qpi_reg;
  assign bus.o_busy      = busy_reg;
endmodule
